rbm_sample_sequencer: RTL and testbench



---
 rtl/rbm_sample_sequencer_pkg.sv | 8 +
 rtl/rbm_sample_sequencer_if.sv | 31 +++
 rtl/rbm_sample_sequencer_argmax.sv | 38 +++
 rtl/rbm_sample_sequencer.sv | 107 ++++++++++
 tb/tb_rbm_sample_sequencer.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/rbm_sample_sequencer_pkg.sv
// rbm_seq_pkg: shared FSM encoding, width helper and result counter width for the RBM sample sequencer
package rbm_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_ARGMAX, S_REPORT} state_e;
  localparam int COUNT_W = 16;
  function automatic int cls_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rbm_sample_sequencer_if.sv
// rbm_sample_sequencer_if: sample input, engine and result streams; master is the sequencer side
interface rbm_sample_sequencer_if #(
  parameter int bitlength  = 12,
  parameter int input_dim  = 15,
  parameter int output_dim = 2
);
  logic                                      in_valid;
  logic                                      in_ready;
  logic [input_dim*bitlength-1:0]            in_data;
  logic                                      eng_reset;
  logic                                      eng_data_valid;
  logic [input_dim*bitlength-1:0]            eng_input;
  logic [output_dim*bitlength-1:0]           eng_output;
  logic                                      eng_finish;
  logic                                      res_valid;
  logic                                      res_ready;
  logic [rbm_seq_pkg::cls_w(output_dim)-1:0] res_class;
  logic [output_dim*bitlength-1:0]           res_scores;
  logic [rbm_seq_pkg::COUNT_W-1:0]           res_count;
  logic                                      res_timeout;
  modport master (
    input  in_valid, in_data, eng_output, eng_finish, res_ready,
    output in_ready, eng_reset, eng_data_valid, eng_input,
           res_valid, res_class, res_scores, res_count, res_timeout
  );
  modport slave (
    output in_valid, in_data, eng_output, eng_finish, res_ready,
    input  in_ready, eng_reset, eng_data_valid, eng_input,
           res_valid, res_class, res_scores, res_count, res_timeout
  );
endinterface

// File: rtl/rbm_sample_sequencer_argmax.sv
// rbm_argmax: one-word-per-cycle signed argmax, seeded with word 0, ties keep the lowest index
module rbm_argmax
  import rbm_seq_pkg::*;
#(
  parameter int bitlength  = 12,
  parameter int output_dim = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start_i,
  input  logic [output_dim*bitlength-1:0]   scores_i,
  output logic                              done_o,
  output logic [cls_w(output_dim)-1:0]      index_o
);
  localparam int IW = cls_w(output_dim);
  logic [IW-1:0] cnt_q, idx_q, pos;
  logic busy_q, active, take;
  logic signed [bitlength-1:0] best_q, word;
  assign active  = start_i | busy_q;
  assign pos     = start_i ? '0 : cnt_q;
  assign word    = scores_i[pos*bitlength +: bitlength];
  assign take    = start_i | (word > best_q);
  assign done_o  = active & (pos == IW'(output_dim - 1));
  assign index_o = take ? pos : idx_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      best_q <= '0;
      busy_q <= 1'b0;
    end else if (active) begin
      cnt_q  <= pos + 1'b1;
      idx_q  <= index_o;
      best_q <= take ? word : best_q;
      busy_q <= ~done_o;
    end
  end
endmodule

// File: rtl/rbm_sample_sequencer.sv
// rbm_sample_sequencer: buffers samples, sequences the RBM engine and returns argmax results; RBM_SEQ_TIMEOUT_EN adds a RUN watchdog
module rbm_sample_sequencer
  import rbm_seq_pkg::*;
#(
  parameter int bitlength      = 12,
  parameter int input_dim      = 15,
  parameter int output_dim     = 2,
  parameter int ENG_RST_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                   clock,
  input logic                   reset,
  rbm_sample_sequencer_if.master bus
);
  localparam int DW = input_dim * bitlength;
  localparam int SW = output_dim * bitlength;
  localparam int CW = cls_w(output_dim);
  localparam int RW = $clog2(ENG_RST_CYCLES + 1);
  if (ENG_RST_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_err
    $error("ENG_RST_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end
  state_e state_q, state_d;
  logic               buf_full_q, am_start_q, am_done;
  logic [DW-1:0]      buf_q, eng_in_q;
  logic [RW-1:0]      rst_cnt_q;
  logic [SW-1:0]      scores_q;
  logic [CW-1:0]      class_q, am_index;
  logic [COUNT_W-1:0] count_q;
  logic               accept, go, rst_last, tmo, latch, rst_phase;
  assign accept   = bus.in_valid & ~buf_full_q;
  assign go       = (state_q == S_IDLE) & buf_full_q;
  assign rst_last = rst_cnt_q == RW'(ENG_RST_CYCLES - 1);
  assign latch    = (state_q == S_RUN) & (bus.eng_finish | tmo);
`ifdef RBM_SEQ_TIMEOUT_EN
  logic [31:0] run_cnt_q;
  logic        timeout_q;
  assign tmo             = (state_q == S_RUN) & (run_cnt_q == 32'(TIMEOUT_CYCLES - 1));
  assign bus.res_timeout = timeout_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      run_cnt_q <= (state_q == S_RUN) ? run_cnt_q + 32'd1 : '0;
      timeout_q <= go ? 1'b0 : (latch & ~bus.eng_finish) ? 1'b1 : timeout_q;
    end
  end
`else
  assign tmo             = 1'b0;
  assign bus.res_timeout = 1'b0;
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = buf_full_q    ? S_RST    : S_IDLE;
      S_RST:    state_d = rst_last      ? S_RUN    : S_RST;
      S_RUN:    state_d = latch         ? S_ARGMAX : S_RUN;
      S_ARGMAX: state_d = am_done       ? S_REPORT : S_ARGMAX;
      S_REPORT: state_d = bus.res_ready ? S_IDLE   : S_REPORT;
      default:  state_d = S_IDLE;
    endcase
  end
  always_comb begin
    rst_phase          = state_q == S_RST;
    bus.eng_reset      = reset | rst_phase;
    bus.eng_data_valid = state_q == S_RUN;
    bus.res_valid      = state_q == S_REPORT;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      eng_in_q   <= '0;
      rst_cnt_q  <= '0;
      scores_q   <= '0;
      am_start_q <= 1'b0;
      class_q    <= '0;
      count_q    <= '0;
    end else begin
      buf_full_q <= accept | (buf_full_q & ~go);
      if (accept) buf_q <= bus.in_data;
      if (go) eng_in_q <= buf_q;
      rst_cnt_q  <= rst_phase ? rst_cnt_q + 1'b1 : '0;
      if (latch) scores_q <= bus.eng_output;
      am_start_q <= latch;
      if (state_q == S_ARGMAX && am_done) class_q <= am_index;
      if (bus.res_valid && bus.res_ready) count_q <= count_q + 1'b1;
    end
  end
  rbm_argmax #(.bitlength(bitlength), .output_dim(output_dim)) u_argmax (
    .clock   (clock),
    .reset   (reset),
    .start_i (am_start_q),
    .scores_i(scores_q),
    .done_o  (am_done),
    .index_o (am_index)
  );
  assign bus.in_ready   = ~buf_full_q;
  assign bus.eng_input  = eng_in_q;
  assign bus.res_scores = scores_q;
  assign bus.res_class  = class_q;
  assign bus.res_count  = count_q;
endmodule

// File: tb/tb_rbm_sample_sequencer.sv
// tb_rbm_sample_sequencer: directed scenario tasks for the RBM sample sequencer
module tb_rbm_sample_sequencer;
  localparam int BL = 12, ID = 15, OD = 2, NR = 2, TO = 50;
  logic clock = 1'b0;
  logic reset;
  int errors = 0, checks = 0;
  always #5 clock = ~clock;
  rbm_sample_sequencer_if #(.bitlength(BL), .input_dim(ID), .output_dim(OD)) bus ();
  rbm_sample_sequencer #(
    .bitlength(BL), .input_dim(ID), .output_dim(OD),
    .ENG_RST_CYCLES(NR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );
  function automatic logic [ID*BL-1:0] mk(input int seed);
    logic [ID*BL-1:0] v;
    for (int i = 0; i < ID; i++) v[i*BL +: BL] = BL'(seed * 16 + i);
    return v;
  endfunction
  task automatic wait_sig(input bit res, input int limit, output int e);
    e = 0;
    while ((res ? !bus.res_valid : !bus.eng_data_valid) && e < limit) begin
      @(negedge clock);
      e++;
    end
  endtask
  task automatic pulse_finish(input logic [BL-1:0] s0, input logic [BL-1:0] s1, input int delay);
    repeat (delay - 1) @(negedge clock);
    bus.eng_output = {s1, s0};
    bus.eng_finish = 1'b1;
    @(negedge clock);
    bus.eng_finish = 1'b0;
  endtask
  task automatic offer(input logic [ID*BL-1:0] smp);
    bus.in_valid = 1'b1;
    bus.in_data  = smp;
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask
  task automatic run_one(input string nm, input logic [ID*BL-1:0] smp, input logic [BL-1:0] s0,
                         input logic [BL-1:0] s1, input logic exp_cls, input logic [15:0] exp_cnt);
    int e;
    bus.res_ready = 1'b1;
    offer(smp);
    checks++; if (bus.in_ready !== 1'b0 || bus.eng_reset !== 1'b0) begin errors++; $display("FAIL %s accept: in_ready=%b eng_reset=%b want 0 0", nm, bus.in_ready, bus.eng_reset); end
    @(negedge clock);
    checks++; if (bus.eng_reset !== 1'b1 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL %s rst_start: eng_reset=%b in_ready=%b want 1 1", nm, bus.eng_reset, bus.in_ready); end
    checks++; if (bus.eng_input !== smp) begin errors++; $display("FAIL %s eng_input: got %h want %h", nm, bus.eng_input, smp); end
    wait_sig(1'b0, 20, e);
    checks++; if (e !== NR || bus.eng_reset !== 1'b0) begin errors++; $display("FAIL %s run_latency: got %0d eng_reset=%b want %0d 0", nm, e, bus.eng_reset, NR); end
    pulse_finish(s0, s1, 20);
    checks++; if (bus.eng_data_valid !== 1'b0) begin errors++; $display("FAIL %s data_valid_drop: got %b want 0", nm, bus.eng_data_valid); end
    wait_sig(1'b1, 10, e);
    checks++; if (e !== OD) begin errors++; $display("FAIL %s res_latency: got %0d want %0d", nm, e, OD); end
    checks++; if (bus.res_class !== exp_cls) begin errors++; $display("FAIL %s res_class: got %0d want %0d", nm, bus.res_class, exp_cls); end
    checks++; if (bus.res_scores !== {s1, s0}) begin errors++; $display("FAIL %s res_scores: got %h want %h", nm, bus.res_scores, {s1, s0}); end
    checks++; if (bus.res_timeout !== 1'b0) begin errors++; $display("FAIL %s res_timeout: got %b want 0", nm, bus.res_timeout); end
    @(negedge clock);
    checks++; if (bus.res_valid !== 1'b0 || bus.res_count !== exp_cnt) begin errors++; $display("FAIL %s handshake: res_valid=%b res_count=%0d want 0 %0d", nm, bus.res_valid, bus.res_count, exp_cnt); end
  endtask
  task automatic test_reset();
    bus.in_valid = 0; bus.in_data = '0; bus.eng_output = '0; bus.eng_finish = 0; bus.res_ready = 0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (bus.in_ready !== 1'b1 || bus.eng_reset !== 1'b1 || bus.eng_data_valid !== 1'b0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_ctl: in_ready=%b eng_reset=%b dv=%b res_valid=%b want 1 1 0 0", bus.in_ready, bus.eng_reset, bus.eng_data_valid, bus.res_valid); end
    checks++; if (bus.eng_input !== '0 || bus.res_scores !== '0 || bus.res_class !== '0 || bus.res_count !== '0 || bus.res_timeout !== 1'b0) begin errors++; $display("FAIL reset_data: input=%h scores=%h class=%0d count=%0d tmo=%b want zeros", bus.eng_input, bus.res_scores, bus.res_class, bus.res_count, bus.res_timeout); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if (bus.eng_reset !== 1'b0) begin errors++; $display("FAIL reset_release: eng_reset=%b want 0", bus.eng_reset); end
  endtask
  task automatic test_scores();
    run_one("single",  mk(1), 12'h0A0, 12'h1F0, 1'b1, 16'd1);
    run_one("tie",     mk(2), 12'h050, 12'h050, 1'b0, 16'd2);
    run_one("negative", mk(3), 12'hF80, 12'hF00, 1'b0, 16'd3);
    run_one("minneg",  mk(4), 12'h800, 12'h001, 1'b1, 16'd4);
  endtask
  task automatic test_back_to_back();
    int e;
    bus.res_ready = 1'b1;
    offer(mk(5));
    wait_sig(1'b0, 20, e);
    offer(mk(6));
    checks++; if (bus.in_ready !== 1'b0 || bus.eng_input !== mk(5)) begin errors++; $display("FAIL b2b_buffered: in_ready=%b eng_input=%h want 0 %h", bus.in_ready, bus.eng_input, mk(5)); end
    pulse_finish(12'h100, 12'h0FF, 5);
    wait_sig(1'b1, 10, e);
    checks++; if (bus.res_class !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_first: class=%0d in_ready=%b want 0 0", bus.res_class, bus.in_ready); end
    @(negedge clock);
    checks++; if (bus.res_valid !== 1'b0 || bus.eng_reset !== 1'b0 || bus.res_count !== 16'd5) begin errors++; $display("FAIL b2b_idle: res_valid=%b eng_reset=%b count=%0d want 0 0 5", bus.res_valid, bus.eng_reset, bus.res_count); end
    @(negedge clock);
    checks++; if (bus.eng_reset !== 1'b1 || bus.eng_input !== mk(6) || bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_restart: eng_reset=%b eng_input=%h in_ready=%b want 1 %h 1", bus.eng_reset, bus.eng_input, bus.in_ready, mk(6)); end
    wait_sig(1'b0, 20, e);
    checks++; if (e !== NR) begin errors++; $display("FAIL b2b_run_latency: got %0d want %0d", e, NR); end
    pulse_finish(12'h001, 12'h002, 3);
    wait_sig(1'b1, 10, e);
    checks++; if (bus.res_class !== 1'b1 || bus.res_scores !== 24'h002001) begin errors++; $display("FAIL b2b_second: class=%0d scores=%h want 1 002001", bus.res_class, bus.res_scores); end
    @(negedge clock);
    checks++; if (bus.res_count !== 16'd6) begin errors++; $display("FAIL b2b_count: got %0d want 6", bus.res_count); end
  endtask
  task automatic test_hold();
    int e;
    bus.res_ready = 1'b0;
    offer(mk(7));
    wait_sig(1'b0, 20, e);
    offer(mk(8));
    pulse_finish(12'h3A5, 12'h3A6, 4);
    wait_sig(1'b1, 10, e);
    checks++; if (e !== OD || bus.res_class !== 1'b1) begin errors++; $display("FAIL hold_first: latency=%0d class=%0d want %0d 1", e, bus.res_class, OD); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_class !== 1'b1 || bus.res_scores !== 24'h3A63A5 ||
          bus.eng_reset !== 1'b0 || bus.eng_data_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: rv=%b cls=%0d sc=%h er=%b dv=%b ir=%b want 1 1 3a63a5 0 0 0", i, bus.res_valid, bus.res_class, bus.res_scores, bus.eng_reset, bus.eng_data_valid, bus.in_ready);
      end
    end
    bus.res_ready = 1'b1;
    @(negedge clock);
    bus.res_ready = 1'b0;
    checks++; if (bus.res_valid !== 1'b0 || bus.res_count !== 16'd7) begin errors++; $display("FAIL hold_release: res_valid=%b count=%0d want 0 7", bus.res_valid, bus.res_count); end
  endtask
  task automatic test_reset_mid();
    int e;
    wait_sig(1'b0, 20, e);
    checks++; if (e !== NR + 1 || bus.eng_input !== mk(8)) begin errors++; $display("FAIL mid_run_start: latency=%0d input=%h want %0d %h", e, bus.eng_input, NR + 1, mk(8)); end
    offer(mk(10));
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (bus.eng_reset !== 1'b1 || bus.eng_data_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ctl: er=%b dv=%b ir=%b want 1 0 1", bus.eng_reset, bus.eng_data_valid, bus.in_ready); end
    checks++; if (bus.res_count !== '0 || bus.eng_input !== '0 || bus.res_scores !== '0) begin errors++; $display("FAIL mid_reset_data: count=%0d input=%h scores=%h want zeros", bus.res_count, bus.eng_input, bus.res_scores); end
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    checks++; if (bus.eng_reset !== 1'b0 || bus.eng_data_valid !== 1'b0) begin errors++; $display("FAIL mid_discard: er=%b dv=%b want 0 0", bus.eng_reset, bus.eng_data_valid); end
    run_one("after_reset", mk(11), 12'h123, 12'h045, 1'b0, 16'd1);
  endtask
  task automatic test_timeout();
    int e;
    bus.res_ready = 1'b1;
    bus.eng_output = {12'h010, 12'h020};
    offer(mk(12));
    wait_sig(1'b0, 20, e);
`ifdef RBM_SEQ_TIMEOUT_EN
    wait_sig(1'b1, TO + 30, e);
    checks++; if (e !== TO + OD || bus.res_timeout !== 1'b1) begin errors++; $display("FAIL timeout_fire: latency=%0d tmo=%b want %0d 1", e, bus.res_timeout, TO + OD); end
    checks++; if (bus.res_class !== 1'b0 || bus.res_scores !== 24'h010020) begin errors++; $display("FAIL timeout_data: class=%0d scores=%h want 0 010020", bus.res_class, bus.res_scores); end
    @(negedge clock);
    offer(mk(13));
    @(negedge clock);
    checks++; if (bus.res_timeout !== 1'b0 || bus.eng_reset !== 1'b1) begin errors++; $display("FAIL timeout_clear: tmo=%b er=%b want 0 1", bus.res_timeout, bus.eng_reset); end
    wait_sig(1'b0, 20, e);
    pulse_finish(12'h020, 12'h030, 2);
    wait_sig(1'b1, 10, e);
    @(negedge clock);
    checks++; if (bus.res_count !== 16'd3) begin errors++; $display("FAIL timeout_count: got %0d want 3", bus.res_count); end
`else
    repeat (TO + 50) @(negedge clock);
    checks++; if (bus.eng_data_valid !== 1'b1 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL no_timeout_wait: dv=%b rv=%b want 1 0", bus.eng_data_valid, bus.res_valid); end
    pulse_finish(12'h020, 12'h030, 1);
    wait_sig(1'b1, 10, e);
    checks++; if (bus.res_timeout !== 1'b0 || bus.res_class !== 1'b1) begin errors++; $display("FAIL no_timeout_result: tmo=%b class=%0d want 0 1", bus.res_timeout, bus.res_class); end
    @(negedge clock);
    checks++; if (bus.res_count !== 16'd2) begin errors++; $display("FAIL no_timeout_count: got %0d want 2", bus.res_count); end
`endif
  endtask
  initial begin
    test_reset();
    test_scores();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
